hc86_tester: RTL and testbench
==============================

HC86_TESTER -- requirements
Module: hc86_tester

Interface
REQ-001 SETTLE_CYCLES, default 4, number of cycles to wait between driving a vector and sampling the response; legal range 3..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  level-sampled request to begin a test run; acted on only in IDLE.
REQ-005 abort  input  1  terminates a run in progress; ignored in IDLE.
REQ-006 dut_y  input  4  outputs of the four XOR gates of the device under test, asynchronous to clk.
REQ-007 dut_a  output  4  A inputs driven to the four gates, registered.
REQ-008 dut_b  output  4  B inputs driven to the four gates, registered.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a run completes normally.
REQ-011 pass  output  1  high when the last completed run found no mismatch.
REQ-012 fail_mask  output  4  bit n set when gate n mismatched on any vector.
REQ-013 err_count  output  5  total per-gate mismatches in the run, 0..16.

Function
REQ-014 The vector table SHALL be applied in order idx0 (a=0,b=0), idx1 (1,0), idx2 (1,1), idx3 (0,1), with the same a/b on all four gates.
REQ-015 The FSM SHALL have the states IDLE, APPLY, SETTLE, SAMPLE and DONE.
REQ-016 IDLE→APPLY SHALL occur on start=1; APPLY SHALL last 1 cycle and load dut_a/dut_b with the vector for the current idx.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles.
REQ-018 SAMPLE SHALL last 1 cycle and compare synchronized dut_y against {4{a^b}}.
REQ-019 On a mismatch, SAMPLE SHALL OR the mismatch bits into fail_mask and add their popcount to err_count.
REQ-020 After SAMPLE, the FSM SHALL go to APPLY with idx+1 if idx<3, otherwise to DONE.
REQ-021 DONE SHALL last 1 cycle, assert done, set pass=(fail_mask==0), drive dut_a=dut_b=0, and return to IDLE.
REQ-022 Latency SHALL be 1+4*(SETTLE_CYCLES+2) cycles from the edge that samples start to done high; this is 25 cycles at the default.
REQ-023 Accepting start SHALL clear fail_mask, err_count and pass to 0 and set idx to 0.
REQ-024 start held high SHALL launch a new run only on re-entry to IDLE, i.e. one cycle after DONE.
REQ-025 abort SHALL take priority over every other transition and move the FSM to IDLE at the next edge.
REQ-026 An abort SHALL drive dut_a=dut_b=0, produce no done pulse, and leave pass=0 with partial fail_mask/err_count visible.
REQ-027 dut_y SHALL pass through a 2-flop synchronizer before comparison; SETTLE_CYCLES≥3 covers the synchronizer delay plus 1 cycle of gate settling.

Reset
REQ-028 On rst_n low, the FSM SHALL go to IDLE with idx=0, dut_a=0, dut_b=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0 and synchronizer flops=0.
REQ-029 Reset asserted mid-run SHALL abandon the run with no done pulse.

Configuration
REQ-030 When HC86_TESTER_MISR_EN is defined, an 8-bit output sig SHALL be present.
REQ-031 With the macro defined, sig SHALL be seeded to 8'hFF on accepted start and updated in each SAMPLE as {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} XOR {4'b0, dut_y_sync}.
REQ-032 With the macro defined, sig SHALL reset to 8'hFF.
REQ-033 When HC86_TESTER_MISR_EN is undefined, the sig port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-034 Package hc86_tester_pkg SHALL hold the state enumeration, VEC_COUNT=4, the vector table constants (VEC_A, VEC_B) and the MISR seed.
REQ-035 Sub-module hc86_sync SHALL implement the 4-bit 2-flop synchronizer with asynchronous active-low reset.

Verification
REQ-036 Good XOR model, single start pulse → done exactly 25 cycles later, pass=1, fail_mask=0000, err_count=0.
REQ-037 Gate 2 output stuck-at-0 → fail_mask=0100, err_count=2 (idx1 and idx3), pass=0.
REQ-038 All gates inverted (XNOR) → fail_mask=1111, err_count=16, pass=0.
REQ-039 abort asserted during SETTLE of idx2 → IDLE next cycle, busy=0, dut_a=dut_b=0, no done pulse.
REQ-040 start held high for 60 cycles → two runs, with done pulses at cycles 25 and 51 and busy low only at cycle 26.
REQ-041 Macro defined, good model → sig matches the bench MISR model after 4 samples; rst_n pulsed mid-run → sig=8'hFF and all outputs return to reset values.

Source files
------------

// File: rtl/hc86_tester_pkg.sv
// Shared types and constants for the 74HC86 quad-XOR tester: FSM states,
// stimulus table and MISR seed.
package hc86_tester_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_e;

   localparam int unsigned VEC_COUNT = 4;

   // Bit n holds the a/b value of vector idx n: (0,0) (1,0) (1,1) (0,1).
   localparam logic [VEC_COUNT-1:0] VEC_A = 4'b0110;
   localparam logic [VEC_COUNT-1:0] VEC_B = 4'b1100;

   localparam logic [7:0] MISR_SEED = 8'hFF;

   function automatic logic [4:0] popcount4(input logic [3:0] v);
      return 5'(v[0]) + 5'(v[1]) + 5'(v[2]) + 5'(v[3]);
   endfunction

endpackage

// File: rtl/hc86_sync.sv
// 4-bit two-flop synchronizer bringing the gate outputs into the clk domain.
module hc86_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d_i,
   output logic [3:0] q_o
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/hc86_tester.sv
// Functional tester for a quad 2-input XOR: walks a 4-entry vector table and
// accumulates per-gate mismatches. Define HC86_TESTER_MISR_EN to add the sig MISR.
module hc86_tester
   import hc86_tester_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] dut_y,
   output logic [3:0] dut_a,
   output logic [3:0] dut_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [4:0] err_count
`ifdef HC86_TESTER_MISR_EN
   ,
   output logic [7:0] sig
`endif
);

   state_e     state_q;
   logic [1:0] idx_q;
   logic [3:0] cnt_q;
   logic [3:0] a_q, b_q;
   logic       busy_q, done_q, pass_q;
   logic [3:0] fail_mask_q, fail_mask_d;
   logic [4:0] err_q, err_d;
   logic [3:0] y_sync;
   logic [3:0] exp_y;
   logic [3:0] mism;
   logic [1:0] idx_d;

   hc86_sync u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (dut_y),
      .q_o  (y_sync)
   );

   always_comb begin
      exp_y       = {4{VEC_A[idx_q] ^ VEC_B[idx_q]}};
      mism        = y_sync ^ exp_y;
      fail_mask_d = fail_mask_q | mism;
      err_d       = err_q + popcount4(mism);
      idx_d       = idx_q + 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= '0;
         err_q       <= '0;
      end else begin
         done_q <= 1'b0;
         if (abort && state_q != ST_IDLE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
         end else begin
            case (state_q)
               ST_IDLE: if (start) begin
                  state_q     <= ST_APPLY;
                  busy_q      <= 1'b1;
                  idx_q       <= '0;
                  a_q         <= {4{VEC_A[0]}};
                  b_q         <= {4{VEC_B[0]}};
                  pass_q      <= 1'b0;
                  fail_mask_q <= '0;
                  err_q       <= '0;
               end
               ST_APPLY: begin
                  state_q <= ST_SETTLE;
                  cnt_q   <= 4'(SETTLE_CYCLES - 1);
               end
               ST_SETTLE: begin
                  if (cnt_q == '0) state_q <= ST_SAMPLE;
                  else             cnt_q   <= cnt_q - 4'd1;
               end
               ST_SAMPLE: begin
                  fail_mask_q <= fail_mask_d;
                  err_q       <= err_d;
                  // Vectors are loaded on entry to APPLY so they are stable for the whole settle window.
                  if (idx_q != 2'(VEC_COUNT - 1)) begin
                     state_q <= ST_APPLY;
                     idx_q   <= idx_d;
                     a_q     <= {4{VEC_A[idx_d]}};
                     b_q     <= {4{VEC_B[idx_d]}};
                  end else begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     pass_q  <= (fail_mask_d == '0);
                     a_q     <= '0;
                     b_q     <= '0;
                  end
               end
               ST_DONE: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef HC86_TESTER_MISR_EN
   logic [7:0] sig_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= MISR_SEED;
      end else if (state_q == ST_IDLE && start) begin
         sig_q <= MISR_SEED;
      end else if (state_q == ST_SAMPLE && !abort) begin
         sig_q <= {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3]} ^ {4'b0, y_sync};
      end
   end

   assign sig = sig_q;
`endif

   assign dut_a     = a_q;
   assign dut_b     = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = fail_mask_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_hc86_tester.sv
// Self-checking bench for hc86_tester with a behavioural quad-XOR model that
// can be faulted. Covers the sig MISR when HC86_TESTER_MISR_EN is defined.
module tb_hc86_tester;

   localparam int unsigned SETTLE = 4;
   localparam int          LAT    = 1 + 4 * (SETTLE + 2);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] dut_y;
   logic [3:0] dut_a, dut_b, fail_mask;
   logic       busy, done, pass;
   logic [4:0] err_count;
`ifdef HC86_TESTER_MISR_EN
   logic [7:0] sig;
`endif

   int mode = 0;  // 0 good XOR, 1 gate 2 stuck-at-0, 2 all gates XNOR
   int cmp_n = 0;
   int err_n = 0;

   typedef struct {
      logic [3:0] mask;
      logic [4:0] err;
      logic       pass;
      logic [7:0] sig;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic [3:0] gate(input int m, input logic [3:0] a, input logic [3:0] b);
      logic [3:0] y;
      y = a ^ b;
      if (m == 1) y[2] = 1'b0;
      else if (m == 2) y = ~y;
      return y;
   endfunction

   always_comb dut_y = gate(mode, dut_a, dut_b);

   function automatic exp_t model(input int m);
      logic [3:0] ta, tb, y, want;
      exp_t e;
      ta = 4'b0110;  // a of idx0..idx3 = 0,1,1,0
      tb = 4'b1100;  // b of idx0..idx3 = 0,0,1,1
      e.mask = '0;
      e.err  = '0;
      e.sig  = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         y    = gate(m, {4{ta[i]}}, {4{tb[i]}});
         want = {4{ta[i] ^ tb[i]}};
         e.mask |= y ^ want;
         for (int j = 0; j < 4; j++) e.err += 5'(y[j] != want[j]);
         e.sig = {e.sig[6:0], e.sig[7] ^ e.sig[5] ^ e.sig[4] ^ e.sig[3]} ^ {4'b0, y};
      end
      e.pass = (e.mask == '0);
      return e;
   endfunction

   hc86_tester #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .dut_y    (dut_y),
      .dut_a    (dut_a),
      .dut_b    (dut_b),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .fail_mask(fail_mask),
      .err_count(err_count)
`ifdef HC86_TESTER_MISR_EN
      ,
      .sig      (sig)
`endif
   );

   // Cycle 1 is the period right after the edge that samples start.
   task automatic launch_and_wait(output int lat, output bit seen);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      lat  = 1;
      seen = 1'b0;
      while (lat <= LAT + 20) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cmp_n++; if ({busy, done, pass} !== 3'b000) begin err_n++; $display("FAIL reset_flags: got %b want 000", {busy, done, pass}); end
      cmp_n++; if ({dut_a, dut_b} !== 8'h00) begin err_n++; $display("FAIL reset_ab: got %h want 00", {dut_a, dut_b}); end
      cmp_n++; if (fail_mask !== 4'h0) begin err_n++; $display("FAIL reset_mask: got %b want 0000", fail_mask); end
      cmp_n++; if (err_count !== 5'd0) begin err_n++; $display("FAIL reset_err: got %0d want 0", err_count); end
`ifdef HC86_TESTER_MISR_EN
      cmp_n++; if (sig !== 8'hFF) begin err_n++; $display("FAIL reset_sig: got %h want ff", sig); end
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_good();
      int   lat;
      bit   seen;
      exp_t e;
      mode = 0;
      sb.push_back(model(0));
      launch_and_wait(lat, seen);
      e = sb.pop_front();
      cmp_n++; if (!seen || lat != LAT) begin err_n++; $display("FAIL good_latency: got %0d (seen=%0b) want %0d", lat, seen, LAT); end
      cmp_n++; if (pass !== e.pass) begin err_n++; $display("FAIL good_pass: got %b want %b", pass, e.pass); end
      cmp_n++; if (fail_mask !== e.mask) begin err_n++; $display("FAIL good_mask: got %b want %b", fail_mask, e.mask); end
      cmp_n++; if (err_count !== e.err) begin err_n++; $display("FAIL good_err: got %0d want %0d", err_count, e.err); end
      cmp_n++; if ({dut_a, dut_b, busy} !== 9'h001) begin err_n++; $display("FAIL good_done_state: got ab=%h busy=%b want ab=00 busy=1", {dut_a, dut_b}, busy); end
`ifdef HC86_TESTER_MISR_EN
      cmp_n++; if (sig !== e.sig) begin err_n++; $display("FAIL good_sig: got %h want %h", sig, e.sig); end
`endif
      @(posedge clk); #1;
      cmp_n++; if ({done, busy, pass} !== 3'b001) begin err_n++; $display("FAIL good_after_done: got done,busy,pass=%b want 001", {done, busy, pass}); end
   endtask

   task automatic test_faults();
      int   lat;
      bit   seen;
      exp_t e;
      for (int m = 1; m <= 2; m++) begin
         mode = m;
         sb.push_back(model(m));
         launch_and_wait(lat, seen);
         e = sb.pop_front();
         cmp_n++; if (!seen) begin err_n++; $display("FAIL fault%0d_timeout: no done within %0d cycles", m, LAT + 20); end
         cmp_n++; if (fail_mask !== e.mask) begin err_n++; $display("FAIL fault%0d_mask: got %b want %b", m, fail_mask, e.mask); end
         cmp_n++; if (err_count !== e.err) begin err_n++; $display("FAIL fault%0d_err: got %0d want %0d", m, err_count, e.err); end
         cmp_n++; if (pass !== e.pass) begin err_n++; $display("FAIL fault%0d_pass: got %b want %b", m, pass, e.pass); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_abort();
      int n;
      int dones;
      mode = 2;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      while (!(dut_a == 4'hF && dut_b == 4'hF) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      cmp_n++; if (n >= 40) begin err_n++; $display("FAIL abort_reach_idx2: got ab=%h want ff", {dut_a, dut_b}); end
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      cmp_n++; if ({busy, done, pass} !== 3'b000) begin err_n++; $display("FAIL abort_flags: got %b want 000", {busy, done, pass}); end
      cmp_n++; if ({dut_a, dut_b} !== 8'h00) begin err_n++; $display("FAIL abort_ab: got %h want 00", {dut_a, dut_b}); end
      // idx0 and idx1 were sampled with every gate inverted: 2 vectors x 4 gates.
      cmp_n++; if ({fail_mask, err_count} !== {4'hF, 5'd8}) begin err_n++; $display("FAIL abort_partial: got mask=%b err=%0d want 1111/8", fail_mask, err_count); end
      dones = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      cmp_n++; if (dones != 0) begin err_n++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
   endtask

   task automatic test_back_to_back();
      int   done_cyc[$];
      int   low_cyc[$];
      exp_t e;
      mode = 0;
      sb.push_back(model(0));
      sb.push_back(model(0));
      @(posedge clk); #1 start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         if (done) begin
            done_cyc.push_back(c);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               cmp_n++; if (pass !== e.pass) begin err_n++; $display("FAIL b2b_pass: cycle %0d got %b want %b", c, pass, e.pass); end
            end
         end
         if (!busy && c <= 51) low_cyc.push_back(c);
      end
      start = 1'b0;
      cmp_n++; if (done_cyc.size() != 2 || done_cyc[0] != 25 || done_cyc[1] != 51) begin
         err_n++; $display("FAIL b2b_done_cycles: got %p want '{25, 51}", done_cyc);
      end
      cmp_n++; if (low_cyc.size() != 1 || low_cyc[0] != 26) begin
         err_n++; $display("FAIL b2b_busy_low: got %p want '{26}", low_cyc);
      end
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset_midrun();
      int dones;
      mode = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      cmp_n++; if ({busy, done, pass, dut_a, dut_b} !== 11'h000) begin
         err_n++; $display("FAIL rst_mid_outputs: got busy,done,pass=%b ab=%h want 000/00", {busy, done, pass}, {dut_a, dut_b});
      end
      cmp_n++; if ({fail_mask, err_count} !== 9'h000) begin err_n++; $display("FAIL rst_mid_counts: got mask=%b err=%0d want 0/0", fail_mask, err_count); end
`ifdef HC86_TESTER_MISR_EN
      cmp_n++; if (sig !== 8'hFF) begin err_n++; $display("FAIL rst_mid_sig: got %h want ff", sig); end
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      dones = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done || busy) dones++;
      end
      cmp_n++; if (dones != 0) begin err_n++; $display("FAIL rst_mid_idle: got %0d active cycles want 0", dones); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_good();
      test_faults();
      test_abort();
      test_back_to_back();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
